// File: rtl/clock_set_controller_if.sv
// Key, run-switch and datapath-control signals of the clock set controller.
// master: the controller; slave: the board keys plus the HH:MM:SS datapath.
interface clock_set_controller_if;
  logic       keyModeN;
  logic       keyUpN;
  logic       keyDownN;
  logic       runSw;
  logic       stepEn;
  logic       set;
  logic [1:0] sethms;
  logic [1:0] upDown;
  logic       blink;

  modport master (
    input  keyModeN, keyUpN, keyDownN, runSw,
    output stepEn, set, sethms, upDown, blink
  );

  modport slave (
    output keyModeN, keyUpN, keyDownN, runSw,
    input  stepEn, set, sethms, upDown, blink
  );
endinterface

// File: rtl/clock_set_controller.sv
// Run/set sequencer for the HH:MM:SS clock: key synchronise/debounce, mode FSM,
// 1 Hz prescaler, edit auto-repeat and field blink, all as registered outputs.
module clock_set_controller #(
  parameter int CLK_HZ              = 50_000_000,
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int REPEAT_RATE_CYCLES  = 5_000_000,
  parameter int BLINK_CYCLES        = 12_500_000
) (
  input logic                    clk,
  input logic                    rstN,
  clock_set_controller_if.master bus
);

  localparam int PW   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam int BW   = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam int KM   = 0;
  localparam int KU   = 1;
  localparam int KD   = 2;

  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

  logic [2:0]    keyRaw, sync_p0, sync_p1, stable, press;
  logic [DW-1:0] dbCnt [3];

  state_t        state, stateN;
  logic [PW-1:0] pres, presN;
  logic [RW-1:0] rptCnt, rptCntN, rptLimit;
  logic          rptFirst, rptFirstN, armed, armedN;
  logic [BW-1:0] blinkCnt, blinkCntN;
  logic          blinkR, blinkN, stepR, stepN, setR, setN;
  logic [1:0]    hmsR, hmsN, udR, udN;
  logic          upHeld, downHeld;

  assign keyRaw = {bus.keyDownN, bus.keyUpN, bus.keyModeN};

  // Stage p0/p1: two-flop synchroniser, then per-key debounce and press pulse
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      stable  <= '1;
      press   <= '0;
      for (int i = 0; i < 3; i++) dbCnt[i] <= '0;
    end else begin
      sync_p0 <= keyRaw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync_p1[i] == stable[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          dbCnt[i]  <= '0;
          stable[i] <= sync_p1[i];
          press[i]  <= ~sync_p1[i];
        end else begin
          dbCnt[i] <= dbCnt[i] + 1'b1;
        end
      end
    end
  end

  assign upHeld   = ~stable[KU];
  assign downHeld = ~stable[KD];
  assign rptLimit = rptFirst ? RW'(REPEAT_DELAY_CYCLES - 1) : RW'(REPEAT_RATE_CYCLES - 1);

  always_comb begin
    stateN    = state;
    presN     = pres;
    rptCntN   = rptCnt;
    rptFirstN = rptFirst;
    armedN    = armed;
    stepN     = 1'b0;
    udN       = 2'b00;
    blinkN    = blinkR;
    blinkCntN = blinkCnt;
    hmsN      = 2'b11;
    setN      = 1'b0;

    if (press[KM]) begin
      // A mode press wins over any step decoded in the same cycle
      case (state)
        RUN:     stateN = SET_H;
        SET_H:   stateN = SET_M;
        SET_M:   stateN = SET_S;
        default: stateN = RUN;
      endcase
      presN     = '0;
      rptCntN   = '0;
      rptFirstN = 1'b1;
      armedN    = 1'b0;
    end else if (state == RUN) begin
      rptCntN = '0;
      armedN  = 1'b0;
      if (bus.runSw) begin
        if (pres == PW'(CLK_HZ - 1)) begin
          presN = '0;
          stepN = 1'b1;
        end else begin
          presN = pres + 1'b1;
        end
      end
    end else begin
      presN = '0;
      if (upHeld && downHeld) begin
        rptCntN = '0;
        armedN  = 1'b0;
      end else if (press[KU] || press[KD]) begin
        stepN     = 1'b1;
        udN       = press[KU] ? 2'b10 : 2'b01;
        rptCntN   = '0;
        rptFirstN = 1'b1;
        armedN    = 1'b1;
      end else if (armed && (upHeld || downHeld)) begin
        // Only keys pressed in the current state are armed for repeat
        if (rptCnt == rptLimit) begin
          stepN     = 1'b1;
          udN       = upHeld ? 2'b10 : 2'b01;
          rptCntN   = '0;
          rptFirstN = 1'b0;
        end else begin
          rptCntN = rptCnt + 1'b1;
        end
      end else begin
        rptCntN = '0;
        armedN  = 1'b0;
      end
    end

    case (stateN)
      SET_H:   hmsN = 2'b00;
      SET_M:   hmsN = 2'b01;
      SET_S:   hmsN = 2'b10;
      default: hmsN = 2'b11;
    endcase
    setN = (stateN != RUN);

    if (stateN == RUN) begin
      blinkN    = 1'b0;
      blinkCntN = '0;
    end else if (press[KM]) begin
      blinkN    = 1'b1;
      blinkCntN = '0;
    end else if (blinkCnt == BW'(BLINK_CYCLES - 1)) begin
      blinkN    = ~blinkR;
      blinkCntN = '0;
    end else begin
      blinkCntN = blinkCnt + 1'b1;
    end
  end

  // Stage p2: state and registered outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= RUN;
      pres     <= '0;
      rptCnt   <= '0;
      rptFirst <= 1'b1;
      armed    <= 1'b0;
      blinkCnt <= '0;
      blinkR   <= 1'b0;
      stepR    <= 1'b0;
      setR     <= 1'b0;
      hmsR     <= 2'b11;
      udR      <= 2'b00;
    end else begin
      state    <= stateN;
      pres     <= presN;
      rptCnt   <= rptCntN;
      rptFirst <= rptFirstN;
      armed    <= armedN;
      blinkCnt <= blinkCntN;
      blinkR   <= blinkN;
      stepR    <= stepN;
      setR     <= setN;
      hmsR     <= hmsN;
      udR      <= udN;
    end
  end

  assign bus.stepEn = stepR;
  assign bus.set    = setR;
  assign bus.sethms = hmsR;
  assign bus.upDown = udR;
  assign bus.blink  = blinkR;

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller with shortened timing parameters:
// stimulus queues expected steps, a monitor pops one per stepEn pulse.
module tb_clock_set_controller;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int DLY    = 20;
  localparam int RATE   = 5;
  localparam int BLK    = 8;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  clock_set_controller_if bus ();

  clock_set_controller #(
    .CLK_HZ             (CLK_HZ),
    .DEBOUNCE_CYCLES    (DEB),
    .REPEAT_DELAY_CYCLES(DLY),
    .REPEAT_RATE_CYCLES (RATE),
    .BLINK_CYCLES       (BLK)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [1:0] ud;
    logic [1:0] hms;
  } exp_t;

  exp_t q[$];
  exp_t monE;
  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every stepEn pulse must match the head of the queue in cycle and fields
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].at < cyc) begin
      compared++;
      mismatched++;
      monE = q.pop_front();
      $display("FAIL missed_step: no stepEn at cycle %0d, required upDown=%b sethms=%b",
               monE.at, monE.ud, monE.hms);
    end
    if (bus.stepEn === 1'b1) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_step: stepEn=1 at cycle %0d upDown=%b sethms=%b, required no step",
                 cyc, bus.upDown, bus.sethms);
      end else begin
        monE = q.pop_front();
        if (cyc != monE.at || bus.upDown !== monE.ud || bus.sethms !== monE.hms) begin
          mismatched++;
          $display("FAIL step: got cycle %0d upDown=%b sethms=%b, required cycle %0d upDown=%b sethms=%b",
                   cyc, bus.upDown, bus.sethms, monE.at, monE.ud, monE.hms);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_step(input int at, input logic [1:0] ud, input logic [1:0] hms);
    exp_t e;
    e.at  = at;
    e.ud  = ud;
    e.hms = hms;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Low 6 cycles debounces to a press; new state is visible 7 cycles after the drive
  task automatic press_mode();
    bus.keyModeN = 1'b0;
    tick(6);
    bus.keyModeN = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got cycle %0d, required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r0, c, r1;
    bus.keyModeN = 1'b1;
    bus.keyUpN   = 1'b1;
    bus.keyDownN = 1'b1;
    bus.runSw    = 1'b1;
    rstN         = 1'b0;
    tick(3);
    check("reset_stepEn", 32'(bus.stepEn), 0);
    check("reset_set",    32'(bus.set),    0);
    check("reset_sethms", 32'(bus.sethms), 3);
    check("reset_upDown", 32'(bus.upDown), 0);
    check("reset_blink",  32'(bus.blink),  0);

    // RUN ticks, then a 50-cycle pause with the prescaler at 6
    rstN = 1'b1;
    r0   = cyc;
    expect_step(r0 + 10, 2'b00, 2'b11);
    expect_step(r0 + 20, 2'b00, 2'b11);
    expect_step(r0 + 30, 2'b00, 2'b11);
    expect_step(r0 + 90, 2'b00, 2'b11);
    tick(36);
    bus.runSw = 1'b0;
    tick(50);
    bus.runSw = 1'b1;
    tick(5);
    bus.runSw = 1'b0;

    // Mode glitch is filtered, real press enters SET_H with blink on
    bus.keyModeN = 1'b0;
    tick(2);
    bus.keyModeN = 1'b1;
    tick(8);
    check("glitch_set",    32'(bus.set),    0);
    check("glitch_sethms", 32'(bus.sethms), 3);
    press_mode();
    check("seth_set",    32'(bus.set),    1);
    check("seth_sethms", 32'(bus.sethms), 0);
    check("seth_blink",  32'(bus.blink),  1);
    tick(7);
    check("blink_before_toggle", 32'(bus.blink), 1);
    tick(1);
    check("blink_after_toggle", 32'(bus.blink), 0);

    // SET_M: up held 42 cycles keeps the stable value low through press+40
    press_mode();
    check("setm_sethms", 32'(bus.sethms), 1);
    tick(7);
    c = cyc;
    bus.keyUpN = 1'b0;
    expect_step(c + 7,  2'b10, 2'b01);
    expect_step(c + 27, 2'b10, 2'b01);
    expect_step(c + 32, 2'b10, 2'b01);
    expect_step(c + 37, 2'b10, 2'b01);
    expect_step(c + 42, 2'b10, 2'b01);
    expect_step(c + 47, 2'b10, 2'b01);
    tick(42);
    bus.keyUpN = 1'b1;
    tick(15);
    c = cyc;
    bus.keyDownN = 1'b0;
    expect_step(c + 7, 2'b01, 2'b01);
    tick(8);
    bus.keyDownN = 1'b1;
    tick(15);

    // SET_S: simultaneous up/down gives nothing; mode press lands on the first repeat
    press_mode();
    check("sets_sethms", 32'(bus.sethms), 2);
    tick(7);
    bus.keyUpN   = 1'b0;
    bus.keyDownN = 1'b0;
    tick(10);
    bus.keyUpN   = 1'b1;
    bus.keyDownN = 1'b1;
    tick(15);
    bus.runSw  = 1'b1;
    c = cyc;
    bus.keyUpN = 1'b0;
    expect_step(c + 7, 2'b10, 2'b10);
    tick(20);
    bus.keyModeN = 1'b0;
    expect_step(c + 37, 2'b00, 2'b11);
    tick(6);
    bus.keyModeN = 1'b1;
    tick(1);
    check("run_set",    32'(bus.set),    0);
    check("run_sethms", 32'(bus.sethms), 3);
    check("run_blink",  32'(bus.blink),  0);
    tick(13);
    bus.runSw  = 1'b0;
    bus.keyUpN = 1'b1;
    tick(15);

    // Reset in SET_M with up held; the held key is ignored in RUN afterwards
    press_mode();
    tick(7);
    press_mode();
    check("setm2_sethms", 32'(bus.sethms), 1);
    tick(7);
    c = cyc;
    bus.keyUpN = 1'b0;
    expect_step(c + 7, 2'b10, 2'b01);
    tick(10);
    rstN = 1'b0;
    #1;
    check("midreset_stepEn", 32'(bus.stepEn), 0);
    check("midreset_set",    32'(bus.set),    0);
    check("midreset_sethms", 32'(bus.sethms), 3);
    check("midreset_upDown", 32'(bus.upDown), 0);
    check("midreset_blink",  32'(bus.blink),  0);
    bus.runSw = 1'b1;
    tick(2);
    rstN = 1'b1;
    r1   = cyc;
    expect_step(r1 + 10, 2'b00, 2'b11);
    expect_step(r1 + 20, 2'b00, 2'b11);
    tick(22);
    bus.runSw  = 1'b0;
    bus.keyUpN = 1'b1;
    tick(15);

    check("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
